serial_transmitter: RTL and testbench

//   Transmit half of the serial transceiver; it pairs with the receiver on the same

---
 rtl/serial_transmitter_if.sv | 33 +++
 rtl/serial_transmitter.sv | 183 ++++++++++++++++++
 tb/tb_serial_transmitter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_transmitter_if
// Purpose  : Byte handshake between a producer and the serial transmitter.
//            The producer (master) drives tx_data/tx_valid; the transmitter
//            (slave) answers with tx_ready while its holding buffer is empty.
// Signals  : tx_data  [DATA_BITS] byte to send
//            tx_valid             tx_data is valid
//            tx_ready             transmitter can take a byte this cycle
// Revision : 1.0 - initial release
// ============================================================================
interface serial_transmitter_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface
`default_nettype wire

// File: rtl/serial_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : serial_transmitter
// Purpose  : Transmit half of the serial transceiver. Bytes arrive over a
//            valid/ready handshake into a one-entry holding buffer and leave
//            on dout as start(0), DATA_BITS data bits LSB first, stop(1).
//            The line idles high; queued frames follow with no idle gap.
// Ports    : clk      system clock, rising edge
//            rst_n    asynchronous reset, active low
//            tx_if    slave side of the byte handshake (tx_data/valid/ready)
//            tx_busy  FSM is in START, DATA or STOP
//            tx_done  one-cycle pulse after a stop bit completes
//            dout     registered serial line output
// Params   : CLK_DIV   clk cycles per bit (2..65535)
//            DATA_BITS data bits per frame (>= 2)
// Revision : 1.0 - initial release
// ============================================================================
module serial_transmitter #(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    serial_transmitter_if.slave   tx_if,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  dout
);

    localparam int c_CNT_W = (CLK_DIV   > 1) ? $clog2(CLK_DIV)   : 1;
    localparam int c_BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_MAX = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE = c_BIT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                 r_state,      w_state_nx;
    logic [c_CNT_W-1:0]     r_cnt,        w_cnt_nx;
    logic [c_BIT_W-1:0]     r_bit_idx,    w_bit_idx_nx;
    logic [DATA_BITS-1:0]   r_shift,      w_shift_nx;
    logic [DATA_BITS-1:0]   r_hold,       w_hold_nx;
    logic                   r_hold_valid, w_hold_valid_nx;
    logic                   r_dout,       w_dout_nx;
    logic                   r_done,       w_done_nx;

    logic                   w_accept;
    logic                   w_cnt_last;
    logic                   w_load;

    // Ready is a pure function of the buffer flag, so an accept (buffer empty)
    // and a load into the shifter (buffer full) can never fall on one edge.
    assign tx_if.tx_ready = ~r_hold_valid;
    assign w_accept       = tx_if.tx_valid & ~r_hold_valid;
    assign w_cnt_last     = (r_cnt == c_CNT_MAX);

    assign tx_busy = (r_state != S_IDLE);
    assign tx_done = r_done;
    assign dout    = r_dout;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_dout       <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_bit_idx    <= w_bit_idx_nx;
            r_shift      <= w_shift_nx;
            r_hold       <= w_hold_nx;
            r_hold_valid <= w_hold_valid_nx;
            r_dout       <= w_dout_nx;
            r_done       <= w_done_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_bit_idx_nx    = r_bit_idx;
        w_shift_nx      = r_shift;
        w_hold_nx       = r_hold;
        w_hold_valid_nx = r_hold_valid;
        w_dout_nx       = r_dout;
        w_done_nx       = 1'b0;
        w_load          = 1'b0;

        if (w_accept) begin
            w_hold_nx       = tx_if.tx_data;
            w_hold_valid_nx = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_dout_nx = 1'b1;
                w_cnt_nx  = '0;
                if (r_hold_valid) begin
                    w_load = 1'b1;
                end
            end

            S_START: begin
                if (w_cnt_last) begin
                    w_state_nx   = S_DATA;
                    w_cnt_nx     = '0;
                    w_bit_idx_nx = '0;
                    w_dout_nx    = r_shift[0];
                end else begin
                    w_cnt_nx = r_cnt + c_CNT_ONE;
                end
            end

            S_DATA: begin
                if (w_cnt_last) begin
                    w_cnt_nx = '0;
                    if (r_bit_idx == c_BIT_MAX) begin
                        w_state_nx = S_STOP;
                        w_dout_nx  = 1'b1;
                    end else begin
                        // The next data bit is shift[1] before the shift lands.
                        w_bit_idx_nx = r_bit_idx + c_BIT_ONE;
                        w_shift_nx   = r_shift >> 1;
                        w_dout_nx    = r_shift[1];
                    end
                end else begin
                    w_cnt_nx = r_cnt + c_CNT_ONE;
                end
            end

            S_STOP: begin
                if (w_cnt_last) begin
                    w_done_nx = 1'b1;
                    w_cnt_nx  = '0;
                    if (r_hold_valid) begin
                        // Queued byte: next start bit begins on this same edge.
                        w_load = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_dout_nx  = 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + c_CNT_ONE;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
                w_dout_nx  = 1'b1;
            end
        endcase

        // Move the held byte into the shifter and drive the start bit.
        if (w_load) begin
            w_state_nx      = S_START;
            w_shift_nx      = r_hold;
            w_hold_valid_nx = 1'b0;
            w_cnt_nx        = '0;
            w_dout_nx       = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_transmitter
// Purpose  : Directed self-checking bench for serial_transmitter. Instance
//            u_dut4 runs at CLK_DIV=4, u_dut2 at CLK_DIV=2. A behavioural
//            receiver samples u_dut4's line at mid-bit for loopback checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_transmitter;

    logic clk = 1'b0;
    logic rst_n;
    logic dout4, busy4, done4;
    logic dout2, busy2, done2;

    int n_checks = 0;
    int n_fail   = 0;

    // Loopback receiver model state
    bit         rx_en    = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    int         rx_count = 0;
    int         rx_err   = 0;

    serial_transmitter_if #(.DATA_BITS(8)) bus4 ();
    serial_transmitter_if #(.DATA_BITS(8)) bus2 ();

    serial_transmitter #(.CLK_DIV(4), .DATA_BITS(8)) u_dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_if   (bus4),
        .tx_busy (busy4),
        .tx_done (done4),
        .dout    (dout4)
    );

    serial_transmitter #(.CLK_DIV(2), .DATA_BITS(8)) u_dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_if   (bus2),
        .tx_busy (busy2),
        .tx_done (done2),
        .dout    (dout2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Receiver at 4 clk per bit: sample the start bit 2 cycles in, then every 4.
    initial begin
        logic [7:0] sh;
        forever begin
            @(negedge dout4);
            if (rx_en) begin
                repeat (2) @(posedge clk);
                #1;
                if (dout4 === 1'b0) begin
                    for (int k = 0; k < 8; k++) begin
                        repeat (4) @(posedge clk);
                        #1;
                        sh[k] = dout4;
                    end
                    repeat (4) @(posedge clk);
                    #1;
                    if (dout4 === 1'b1) begin
                        rx_data  = sh;
                        rx_count = rx_count + 1;
                    end else begin
                        rx_err = rx_err + 1;
                    end
                end else begin
                    rx_err = rx_err + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_dout(input int s);
        return (s == 0) ? dout4 : dout2;
    endfunction

    function automatic logic get_done(input int s);
        return (s == 0) ? done4 : done2;
    endfunction

    function automatic logic get_busy(input int s);
        return (s == 0) ? busy4 : busy2;
    endfunction

    // Called at a negedge with the selected bus ready; returns one negedge
    // after the accepting posedge.
    task automatic send(input int s, input logic [7:0] d);
        if (s == 0) begin
            bus4.tx_data  = d;
            bus4.tx_valid = 1'b1;
        end else begin
            bus2.tx_data  = d;
            bus2.tx_valid = 1'b1;
        end
        @(negedge clk);
        if (s == 0) bus4.tx_valid = 1'b0;
        else        bus2.tx_valid = 1'b0;
    endtask

    // Waits up to max_wait cycles for the start bit, then checks dout and
    // tx_done on every cycle of the frame and the tx_done pulse just after it.
    // Returns at the negedge following the final stop-bit edge.
    task automatic expect_frame(input int s, input logic [7:0] d, input string tag,
                                input int max_wait);
        int         div = (s == 0) ? 4 : 2;
        logic [9:0] f   = {1'b1, d, 1'b0};
        int         n   = 0;
        while (get_dout(s) !== 1'b0 && n < max_wait) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " start"}, {31'd0, get_dout(s)}, 32'd0);
        chk({tag, " busy"}, {31'd0, get_busy(s)}, 32'd1);
        for (int i = 1; i < 10 * div; i++) begin
            @(negedge clk);
            chk($sformatf("%s cyc%0d dout/done", tag, i),
                {30'd0, get_dout(s), get_done(s)}, {30'd0, f[i / div], 1'b0});
        end
        @(negedge clk);
        chk({tag, " done pulse"}, {31'd0, get_done(s)}, 32'd1);
    endtask

    initial begin
        logic [7:0] lb [4];
        lb[0] = 8'h3C; lb[1] = 8'h00; lb[2] = 8'hFF; lb[3] = 8'h01;

        rst_n         = 1'b1;
        bus4.tx_data  = 8'h00;
        bus4.tx_valid = 1'b0;
        bus2.tx_data  = 8'h00;
        bus2.tx_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset dout",  {31'd0, dout4}, 32'd1);
        chk("reset ready", {31'd0, bus4.tx_ready}, 32'd1);
        chk("reset busy",  {31'd0, busy4}, 32'd0);
        chk("reset done",  {31'd0, done4}, 32'd0);
        chk("reset dout2", {31'd0, dout2}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 0xA5: accept edge E0, dout falls at E1
        send(0, 8'hA5);
        chk("t2 ready after accept", {31'd0, bus4.tx_ready}, 32'd0);
        chk("t2 dout still idle",    {31'd0, dout4}, 32'd1);
        expect_frame(0, 8'hA5, "t2", 1);
        chk("t2 busy after stop", {31'd0, busy4}, 32'd0);
        chk("t2 dout idle",       {31'd0, dout4}, 32'd1);
        @(negedge clk);
        chk("t2 done one cycle",  {31'd0, done4}, 32'd0);

        // Reset in the middle of a 0x55 frame
        send(0, 8'h55);
        repeat (10) @(negedge clk);
        chk("t1 mid data bit1", {31'd0, dout4}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t1 async dout",  {31'd0, dout4}, 32'd1);
        chk("t1 async ready", {31'd0, bus4.tx_ready}, 32'd1);
        chk("t1 async busy",  {31'd0, busy4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t1 idle after release", {30'd0, dout4, busy4}, 32'd2);
        end

        // Back-to-back 0x00 then 0xFF with valid held
        bus4.tx_data  = 8'h00;
        bus4.tx_valid = 1'b1;
        @(negedge clk);
        chk("t3 ready drop 1", {31'd0, bus4.tx_ready}, 32'd0);
        bus4.tx_data = 8'hFF;
        @(negedge clk);
        chk("t3 ready rise", {31'd0, bus4.tx_ready}, 32'd1);
        fork
            expect_frame(0, 8'h00, "t3 f1", 0);
            begin
                @(negedge clk);
                chk("t3 ready drop 2", {31'd0, bus4.tx_ready}, 32'd0);
                bus4.tx_valid = 1'b0;
            end
        join
        expect_frame(0, 8'hFF, "t3 f2", 0);
        chk("t3 busy end", {31'd0, busy4}, 32'd0);
        chk("t3 dout end", {31'd0, dout4}, 32'd1);

        // 0x11, 0x22 accepted; 0x33 offered while full is dropped
        bus4.tx_data  = 8'h11;
        bus4.tx_valid = 1'b1;
        @(negedge clk);
        chk("t4 ready full", {31'd0, bus4.tx_ready}, 32'd0);
        bus4.tx_data = 8'h22;
        @(negedge clk);
        chk("t4 ready empty", {31'd0, bus4.tx_ready}, 32'd1);
        fork
            expect_frame(0, 8'h11, "t4 f1", 0);
            begin
                @(negedge clk);
                chk("t4 ready after 0x22", {31'd0, bus4.tx_ready}, 32'd0);
                bus4.tx_data = 8'h33;
                repeat (4) @(negedge clk);
                chk("t4 still full", {31'd0, bus4.tx_ready}, 32'd0);
                bus4.tx_valid = 1'b0;
            end
        join
        expect_frame(0, 8'h22, "t4 f2", 0);
        for (int i = 0; i < 8; i++) begin
            chk("t4 no 0x33 frame", {30'd0, dout4, busy4}, 32'd2);
            @(negedge clk);
        end
        send(0, 8'h33);
        expect_frame(0, 8'h33, "t4 f3", 1);
        chk("t4 busy end", {31'd0, busy4}, 32'd0);

        // CLK_DIV=2, 0x80: 20-cycle frame
        send(1, 8'h80);
        expect_frame(1, 8'h80, "t5", 1);
        chk("t5 busy end", {31'd0, busy2}, 32'd0);
        chk("t5 dout end", {31'd0, dout2}, 32'd1);

        // Loopback into the receiver model
        @(negedge clk);
        rx_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(0, lb[k]);
            expect_frame(0, lb[k], $sformatf("t6 byte%0d", k), 1);
            chk($sformatf("t6 rx_data %0d", k), {24'd0, rx_data}, {24'd0, lb[k]});
            chk($sformatf("t6 rx_count %0d", k), rx_count, k + 1);
            @(negedge clk);
        end
        chk("t6 rx framing errors", rx_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
